period_meter: RTL and testbench
===============================

# period_meter

Measures the period of an external square-wave signal in clock cycles. It is the receive-side counterpart of the team's clock dividers: it recovers the division factor from a divided clock. It sits in the oscilloscope trigger/measurement path. It accumulates a configurable number of consecutive periods of `sig_in` after a `start` request and reports the sum, or a timeout flag if the signal is absent or too slow.

## Interface
- `CNT_W`, 32: width of cycle counters and result.
- `EDGES`, 4: number of consecutive periods accumulated per measurement; legal range 1 to 255.
- `TIMEOUT`, 50_000_000: maximum clock cycles spent waiting or measuring before abort; must be below 2^CNT_W.

- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig_in`  in  1  measured signal, asynchronous to `clk_in`.
- `start`  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when a measurement completes or times out.
- `timeout`  out  1  set with `done` when the measurement aborted; cleared when the next `start` is accepted.
- `period_sum`  out  CNT_W  clock cycles spanning EDGES periods; 0 after a timeout.

## Operation
- Input conditioning:
  - `sig_in` passes a 2-flop synchroniser (s1, s2) plus a delay flop s3.
  - `rise` = s2 & ~s3.
  - All edge references below are to `rise`.
- FSM states are IDLE, ARM, MEAS and DONE.
  - IDLE:
    - `busy`=0.
    - When `start`=1, go to ARM.
    - Clear the timeout counter `tcnt` to 0 and clear `timeout`.
  - ARM:
    - Wait for the first `rise`.
    - On `rise`, go to MEAS with `cnt`<=1 and `ecnt`<=0.
  - MEAS:
    - Each cycle, `cnt`<=`cnt`+1.
    - On `rise`, `ecnt`<=`ecnt`+1.
    - If `ecnt`+1==EDGES on that `rise`, set `period_sum`<=`cnt` and go to DONE.
  - DONE:
    - `done`=1 for exactly one cycle.
    - Go to IDLE.
- Timeout:
  - `tcnt` increments every cycle in ARM and MEAS.
  - If `tcnt`==TIMEOUT-1 and no completion occurs that cycle, then `period_sum`<=0, `timeout`<=1, go to DONE.
  - If completion and timeout coincide, completion wins; `timeout` stays 0.
- A `start` in any state other than IDLE is ignored; it has no effect on counters or outputs.
- `rise` in IDLE or DONE is ignored.
- `period_sum` and `timeout` hold their values until overwritten by the next measurement.
- Width rules:
  - `cnt` and `tcnt` are CNT_W bits; `ecnt` is 8 bits.
  - TIMEOUT < 2^CNT_W guarantees `cnt` never wraps.
- Reset (any time, including mid-measurement):
  - State becomes IDLE.
  - `busy`=0, `done`=0, `timeout`=0, `period_sum`=0.
  - All counters and synchroniser flops are 0.

## Timing
- `start` sampled high in cycle s: state is ARM and `busy`=1 in cycle s+1.
- `sig_in` rising at cycle boundary t appears as `rise` in cycle t+2 (synchroniser latency 2).
- First `rise` in cycle a gives `cnt`=1 in cycle a+1.
- A steady input period of P cycles gives:
  - completing `rise` in cycle a+EDGES·P;
  - `period_sum`=EDGES·P and `done`=1 in cycle a+EDGES·P+1, with `busy` still 1 that cycle;
  - `busy`=0 in the following cycle.
- Timeout: `done`=1, `timeout`=1 in cycle s+TIMEOUT+1.
- Earliest re-start is the cycle after `done`; that is one idle cycle minimum.
- Minimum measurable period is 2 cycles, since `sig_in` high and low must each last at least 1 cycle after synchronisation. Shorter pulses may be missed; this is not an error.

## Test plan
- EDGES=4, `sig_in` period 10 cycles (5 high/5 low), pulse `start` -> `done` one cycle, `period_sum`=40, `timeout`=0, `busy` falls the cycle after `done`.
- EDGES=1, period 7 (3 high/4 low) -> `period_sum`=7. Repeat 3 back-to-back measurements, each `start` the cycle after `done` -> each result 7.
- TIMEOUT=100, `sig_in` held low, `start` in cycle s -> `done`=1 and `timeout`=1 in cycle s+101, `period_sum`=0. Next `start` clears `timeout` one cycle later.
- TIMEOUT=40, EDGES=4, period 10 with first edge arriving immediately -> completion and timeout coincide or timeout first. Check that exactly one `done` pulse occurs and that the result is consistent with the priority rule.
- `start` pulsed again while busy (period 10, EDGES=4) -> ignored; single `done`, `period_sum`=40.
- `rst_n` asserted mid-MEAS -> all outputs 0 immediately (asynchronous). After release, a new `start` measures period 10 correctly -> 40.

Source files
------------

// File: rtl/period_meter.sv
// Period meter: sums EDGES consecutive periods of an asynchronous square wave
// in clk_in cycles, aborting with a timeout flag when the signal is absent or too slow.
module period_meter #(
  parameter int CNT_W   = 32,
  parameter int EDGES   = 4,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] period_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       EDGES_W  = 8'(EDGES);

  state_t           state_r, state_s;
  logic             s1_r, s2_r, s3_r;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] tcnt_r, tcnt_s;
  logic [7:0]       ecnt_r, ecnt_s;
  logic [CNT_W-1:0] sum_s;
  logic             tmo_s;
  logic             complete_s;

  // sig_in synchroniser plus delay flop for edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s = s2_r & ~s3_r;

  // Next-state, counter and result logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    tcnt_s     = tcnt_r;
    ecnt_s     = ecnt_r;
    sum_s      = period_sum;
    tmo_s      = timeout;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        tcnt_s = '0;
        if (start) begin
          state_s = ARM;
          tmo_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
        tcnt_s = tcnt_r + CNT_ONE;
        // A measurement cannot complete here, so the timeout always wins.
        if (tcnt_r == TMO_LAST) begin
          sum_s   = '0;
          tmo_s   = 1'b1;
          state_s = DONE;
        end else if (rise_s) begin
          state_s = MEAS;
          cnt_s   = CNT_ONE;
          ecnt_s  = 8'd0;
        end else begin
          state_s = ARM;
        end
      end
      MEAS: begin
        cnt_s      = cnt_r + CNT_ONE;
        tcnt_s     = tcnt_r + CNT_ONE;
        complete_s = rise_s && ((ecnt_r + 8'd1) == EDGES_W);
        if (rise_s) begin
          ecnt_s = ecnt_r + 8'd1;
        end else begin
          ecnt_s = ecnt_r;
        end
        if (complete_s) begin
          sum_s   = cnt_r;
          state_s = DONE;
        end else if (tcnt_r == TMO_LAST) begin
          sum_s   = '0;
          tmo_s   = 1'b1;
          state_s = DONE;
        end else begin
          state_s = MEAS;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      tcnt_r     <= '0;
      ecnt_r     <= 8'd0;
      period_sum <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      tcnt_r     <= tcnt_s;
      ecnt_r     <= ecnt_s;
      period_sum <= sum_s;
      timeout    <= tmo_s;
      busy       <= (state_s != IDLE);
      done       <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: three instances with different EDGES/TIMEOUT
// share clock, reset and the measured signal; a monitor checks every done pulse.
module tb_period_meter;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        to;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic [2:0]  start_v;
  logic [2:0]  busy_v, done_v, to_v;
  logic [31:0] sum_v [3];

  int   checks = 0;
  int   errors = 0;
  int   gen_hi = 5;
  int   gen_lo = 5;
  bit   gen_en = 1'b0;
  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  period_meter #(.CNT_W(32), .EDGES(4), .TIMEOUT(1000)) u_a (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .timeout(to_v[0]), .period_sum(sum_v[0]));

  period_meter #(.CNT_W(32), .EDGES(1), .TIMEOUT(100)) u_b (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .timeout(to_v[1]), .period_sum(sum_v[1]));

  period_meter #(.CNT_W(32), .EDGES(4), .TIMEOUT(40)) u_c (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .timeout(to_v[2]), .period_sum(sum_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Square-wave source, changes only on falling clock edges
  initial begin
    sig_in = 1'b0;
    forever begin
      if (gen_en) begin
        sig_in = 1'b1;
        repeat (gen_hi) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (gen_lo) @(negedge clk_in);
      end else begin
        sig_in = 1'b0;
        @(negedge clk_in);
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk_in) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k]) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(k), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_dut", 32'(k), 32'(e.id));
          check("period_sum", sum_v[k], e.sum);
          check("timeout_flag", {31'd0, to_v[k]}, {31'd0, e.to});
        end
      end
    end
  end

  task automatic push_exp(input int id, input logic [31:0] sum, input logic to);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    e.to  = to;
    sb.push_back(e);
  endtask

  // Drives start for one sampled cycle; returns at the falling edge of cycle s+1.
  task automatic pulse_start(input int id);
    start_v[id] = 1'b1;
    @(negedge clk_in);
    start_v[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget, output int n);
    n = 1;
    while (!done_v[id] && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("done_seen", {31'd0, done_v[id]}, 32'd1);
  endtask

  task automatic count_done(input int id, input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk_in);
      if (done_v[id]) c++;
    end
  endtask

  initial begin
    int n;
    int c;
    rst_n   = 1'b0;
    start_v = 3'b000;
    repeat (3) @(negedge clk_in);
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", {31'd0, busy_v[k]}, 32'd0);
      check("rst_done", {31'd0, done_v[k]}, 32'd0);
      check("rst_timeout", {31'd0, to_v[k]}, 32'd0);
      check("rst_sum", sum_v[k], 32'd0);
    end
    rst_n = 1'b1;

    // EDGES=4, period 10
    gen_hi = 5; gen_lo = 5; gen_en = 1'b1;
    repeat (20) @(negedge clk_in);
    push_exp(0, 32'd40, 1'b0);
    pulse_start(0);
    check("busy_after_start", {31'd0, busy_v[0]}, 32'd1);
    wait_done(0, 200, n);
    check("busy_at_done", {31'd0, busy_v[0]}, 32'd1);
    @(negedge clk_in);
    check("busy_after_done", {31'd0, busy_v[0]}, 32'd0);
    check("done_one_cycle", {31'd0, done_v[0]}, 32'd0);

    // EDGES=1, period 7, three back-to-back measurements
    gen_hi = 3; gen_lo = 4;
    repeat (20) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 32'd7, 1'b0);
      pulse_start(1);
      wait_done(1, 100, n);
      @(negedge clk_in);
    end

    // TIMEOUT=100 with the signal held low
    gen_en = 1'b0;
    repeat (20) @(negedge clk_in);
    push_exp(1, 32'd0, 1'b1);
    pulse_start(1);
    wait_done(1, 200, n);
    check("tmo_latency", 32'(n), 32'd101);
    @(negedge clk_in);
    check("tmo_held", {31'd0, to_v[1]}, 32'd1);
    push_exp(1, 32'd0, 1'b1);
    pulse_start(1);
    check("tmo_cleared", {31'd0, to_v[1]}, 32'd0);
    wait_done(1, 200, n);
    @(negedge clk_in);

    // TIMEOUT=40, EDGES=4, period 10: the 40-cycle span cannot end before the timeout
    gen_hi = 5; gen_lo = 5;
    push_exp(2, 32'd0, 1'b1);
    gen_en = 1'b1;
    pulse_start(2);
    wait_done(2, 100, n);
    check("tmo40_latency", 32'(n), 32'd41);
    count_done(2, 60, c);
    check("tmo40_single_done", 32'(c), 32'd0);

    // Second start while busy is ignored
    repeat (20) @(negedge clk_in);
    push_exp(0, 32'd40, 1'b0);
    pulse_start(0);
    repeat (15) @(negedge clk_in);
    pulse_start(0);
    wait_done(0, 200, n);
    count_done(0, 60, c);
    check("restart_single_done", 32'(c), 32'd0);

    // Asynchronous reset mid-measurement, then a clean measurement
    repeat (5) @(negedge clk_in);
    pulse_start(0);
    repeat (20) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_v[0]}, 32'd0);
    check("arst_done", {31'd0, done_v[0]}, 32'd0);
    check("arst_timeout", {31'd0, to_v[0]}, 32'd0);
    check("arst_sum", sum_v[0], 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_in);
    push_exp(0, 32'd40, 1'b0);
    pulse_start(0);
    wait_done(0, 200, n);
    repeat (3) @(negedge clk_in);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
